// File: rtl/gat_pkg.sv
// Shared definitions for the coefficient collector.
//   - state_e         : collector FSM states
//   - num_node_width  : width of the node-count field for a given MAX_NODES
//   - softmax_width   : width of the packed word (all slots + node-count field)
//   - slot_lsb        : bit offset of slot k in a vector of total_w bits,
//                       slot 0 at the MSB end
package gat_pkg;

    localparam int DATA_WIDTH_DEF    = 8;
    localparam int MAX_NODES_DEF     = 168;
    localparam int NUM_SUBGRAPHS_DEF = 2708;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        OUTPUT  = 2'd2
    } state_e;

    function automatic int num_node_width(input int max_nodes);
        return $clog2(max_nodes);
    endfunction

    function automatic int softmax_width(input int max_nodes, input int data_width);
        return max_nodes * data_width + $clog2(max_nodes);
    endfunction

    function automatic int slot_lsb(input int k, input int data_width, input int total_w);
        return total_w - (k + 1) * data_width;
    endfunction

endpackage

// File: rtl/coef_pack_buf.sv
// Register buffer holding one subgraph's coefficients.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   clr_i       : zero every slot (wins over a write in the same cycle)
//   we_i        : write wr_data_i into slot wr_idx_i
//   wr_idx_i    : slot index
//   wr_data_i   : coefficient to store
//   vec_o       : flattened slots, slot 0 in the most significant byte
module coef_pack_buf
    import gat_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_NODES  = 168,
    parameter int IDX_W      = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            clr_i,
    input  logic                            we_i,
    input  logic [IDX_W-1:0]                wr_idx_i,
    input  logic [DATA_WIDTH-1:0]           wr_data_i,
    output logic [MAX_NODES*DATA_WIDTH-1:0] vec_o
);

    localparam int VEC_W = MAX_NODES * DATA_WIDTH;

    for (genvar g = 0; g < MAX_NODES; g++) begin : g_slot
        localparam int LSB = slot_lsb(g, DATA_WIDTH, VEC_W);

        logic [DATA_WIDTH-1:0] slot_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                slot_q <= '0;
            end else if (clr_i) begin
                slot_q <= '0;
            end else if (we_i && (wr_idx_i == IDX_W'(g))) begin
                slot_q <= wr_data_i;
            end
        end

        assign vec_o[LSB +: DATA_WIDTH] = slot_q;
    end

endmodule

// File: rtl/coef_collector.sv
// Drains the ReLU'd coefficient FIFO and packs each subgraph's coefficients
// plus its node count into one word for the softmax stage.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | wait for a node count; pop it, clamp it, clear the buffer
//   COLLECT | pop one coefficient per non-empty cycle into slot cnt
//   OUTPUT  | present the packed word until softmax accepts it
//
// Ports:
//   clk, rst_n                          : clock, asynchronous active-low reset
//   coef_ff_dout/empty/rd_vld           : coefficient FIFO (FWFT)
//   num_node_ff_dout/empty/rd_vld       : node-count FIFO (FWFT)
//   sm_data_o, sm_vld_o, sm_rdy_i       : packed word handshake to softmax
//   sg_done_cnt_o                       : accepted words, wraps at NUM_SUBGRAPHS
//   ovf_o                               : sticky, a node count above MAX_NODES arrived
module coef_collector
    import gat_pkg::*;
#(
    parameter  int DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter  int MAX_NODES      = MAX_NODES_DEF,
    parameter  int NUM_SUBGRAPHS  = NUM_SUBGRAPHS_DEF,
    localparam int NUM_NODE_WIDTH = num_node_width(MAX_NODES),
    localparam int SOFTMAX_WIDTH  = softmax_width(MAX_NODES, DATA_WIDTH),
    localparam int SG_CNT_W       = $clog2(NUM_SUBGRAPHS + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [DATA_WIDTH-1:0]     coef_ff_dout,
    input  logic                      coef_ff_empty,
    output logic                      coef_ff_rd_vld,
    input  logic [NUM_NODE_WIDTH-1:0] num_node_ff_dout,
    input  logic                      num_node_ff_empty,
    output logic                      num_node_ff_rd_vld,
    output logic [SOFTMAX_WIDTH-1:0]  sm_data_o,
    output logic                      sm_vld_o,
    input  logic                      sm_rdy_i,
    output logic [SG_CNT_W-1:0]       sg_done_cnt_o,
    output logic                      ovf_o
);

    localparam logic [NUM_NODE_WIDTH-1:0] MAX_N   = NUM_NODE_WIDTH'(MAX_NODES);
    localparam logic [SG_CNT_W-1:0]       SG_LAST = SG_CNT_W'(NUM_SUBGRAPHS - 1);

    state_e state_q, state_d;

    logic [NUM_NODE_WIDTH-1:0] n_q, n_d;
    logic [NUM_NODE_WIDTH-1:0] cnt_q, cnt_d;
    logic [SG_CNT_W-1:0]       sg_cnt_q, sg_cnt_d;
    logic                      ovf_q, ovf_d;

    logic                      num_over;
    logic [NUM_NODE_WIDTH-1:0] n_clamp;
    logic                      last_pop;
    logic                      accept;

    logic                                buf_clr;
    logic                                buf_we;
    logic [MAX_NODES*DATA_WIDTH-1:0]     buf_vec;

    assign num_over = (num_node_ff_dout > MAX_N);
    assign n_clamp  = num_over ? MAX_N : num_node_ff_dout;
    assign last_pop = coef_ff_rd_vld && (cnt_q == n_q - 1'b1);
    assign accept   = sm_vld_o && sm_rdy_i;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!num_node_ff_empty) begin
                    state_d = (n_clamp != '0) ? COLLECT : OUTPUT;
                end
            end
            COLLECT: begin
                if (last_pop) begin
                    state_d = OUTPUT;
                end
            end
            OUTPUT: begin
                if (sm_rdy_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs; the rd_vld strobes are gated by empty so a pop never targets an empty FIFO
    always_comb begin
        num_node_ff_rd_vld = 1'b0;
        coef_ff_rd_vld     = 1'b0;
        sm_vld_o           = 1'b0;
        buf_clr            = 1'b0;
        buf_we             = 1'b0;
        case (state_q)
            IDLE: begin
                num_node_ff_rd_vld = !num_node_ff_empty;
                buf_clr            = !num_node_ff_empty;
            end
            COLLECT: begin
                coef_ff_rd_vld = !coef_ff_empty;
                buf_we         = !coef_ff_empty;
            end
            OUTPUT: begin
                sm_vld_o = 1'b1;
            end
            default: ;
        endcase
    end

    // Node count, slot counter, done counter, overflow flag
    always_comb begin
        n_d      = n_q;
        cnt_d    = cnt_q;
        sg_cnt_d = sg_cnt_q;
        ovf_d    = ovf_q;
        if (num_node_ff_rd_vld) begin
            n_d   = n_clamp;
            cnt_d = '0;
            if (num_over) begin
                ovf_d = 1'b1;
            end
        end
        if (coef_ff_rd_vld) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (accept) begin
            sg_cnt_d = (sg_cnt_q == SG_LAST) ? '0 : sg_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_q      <= '0;
            cnt_q    <= '0;
            sg_cnt_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            n_q      <= n_d;
            cnt_q    <= cnt_d;
            sg_cnt_q <= sg_cnt_d;
            ovf_q    <= ovf_d;
        end
    end

    coef_pack_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .MAX_NODES  (MAX_NODES),
        .IDX_W      (NUM_NODE_WIDTH)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (buf_clr),
        .we_i      (buf_we),
        .wr_idx_i  (cnt_q),
        .wr_data_i (coef_ff_dout),
        .vec_o     (buf_vec)
    );

    // Buffer and n_q only change in IDLE/COLLECT, so the word is stable through OUTPUT
    assign sm_data_o     = {buf_vec, n_q};
    assign sg_done_cnt_o = sg_cnt_q;
    assign ovf_o         = ovf_q;

endmodule

// File: tb/tb_coef_collector.sv
module tb_coef_collector;

    localparam int DW  = 8;
    localparam int MN  = 168;
    localparam int NW  = 8;
    localparam int SW  = MN * DW + NW;
    localparam int SGW = 12;

    typedef logic [SW-1:0] word_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [DW-1:0]  coef_ff_dout;
    logic           coef_ff_empty;
    logic           coef_ff_rd_vld;
    logic [NW-1:0]  num_node_ff_dout;
    logic           num_node_ff_empty;
    logic           num_node_ff_rd_vld;
    logic [SW-1:0]  sm_data_o;
    logic           sm_vld_o;
    logic           sm_rdy_i;
    logic [SGW-1:0] sg_done_cnt_o;
    logic           ovf_o;

    coef_collector #(
        .DATA_WIDTH    (8),
        .MAX_NODES     (168),
        .NUM_SUBGRAPHS (2708)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .coef_ff_dout       (coef_ff_dout),
        .coef_ff_empty      (coef_ff_empty),
        .coef_ff_rd_vld     (coef_ff_rd_vld),
        .num_node_ff_dout   (num_node_ff_dout),
        .num_node_ff_empty  (num_node_ff_empty),
        .num_node_ff_rd_vld (num_node_ff_rd_vld),
        .sm_data_o          (sm_data_o),
        .sm_vld_o           (sm_vld_o),
        .sm_rdy_i           (sm_rdy_i),
        .sg_done_cnt_o      (sg_done_cnt_o),
        .ovf_o              (ovf_o)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] coef_q[$];
    logic [NW-1:0] num_q[$];
    word_t         cap_words[$];
    int            cap_cyc[$];
    logic [DW-1:0] exp_coefs[MN];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int coef_pops = 0;
    int num_pops = 0;
    int viol = 0;
    int last_coef_pop_cyc = 0;
    int vld_rise_cyc = -1;
    int exp_done = 0;
    bit vld_prev = 1'b0;
    bit coef_pop_pend = 1'b0;
    bit num_pop_pend = 1'b0;
    bit starve_en = 1'b0;
    bit coef_block = 1'b0;

    task automatic fifo_refresh();
        coef_ff_empty     = (coef_q.size() == 0) || coef_block;
        coef_ff_dout      = (coef_q.size() != 0) ? coef_q[0] : 8'h00;
        num_node_ff_empty = (num_q.size() == 0);
        num_node_ff_dout  = (num_q.size() != 0) ? num_q[0] : 8'h00;
    endtask

    // Sample everything on the falling edge
    always @(negedge clk) begin
        cyc++;
        coef_pop_pend = coef_ff_rd_vld && !coef_ff_empty;
        num_pop_pend  = num_node_ff_rd_vld && !num_node_ff_empty;
        if (coef_ff_rd_vld && coef_ff_empty) viol++;
        if (num_node_ff_rd_vld && num_node_ff_empty) viol++;
        if (coef_pop_pend) begin
            coef_pops++;
            last_coef_pop_cyc = cyc;
        end
        if (num_pop_pend) num_pops++;
        if (sm_vld_o && !vld_prev) vld_rise_cyc = cyc;
        vld_prev = sm_vld_o;
        if (sm_vld_o && sm_rdy_i) begin
            cap_words.push_back(sm_data_o);
            cap_cyc.push_back(cyc);
        end
    end

    // FIFO model: apply pops just after the rising edge
    always begin
        logic [DW-1:0] dummy;
        @(posedge clk);
        #1;
        if (coef_pop_pend && coef_q.size() != 0) dummy = coef_q.pop_front();
        if (num_pop_pend && num_q.size() != 0) dummy = num_q.pop_front();
        coef_pop_pend = 1'b0;
        num_pop_pend  = 1'b0;
        if (starve_en) coef_block = ~coef_block;
        fifo_refresh();
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic word_t mk_word(input int n);
        word_t w = '0;
        for (int k = 0; k < n; k++) w[SW-1-k*DW -: DW] = exp_coefs[k];
        w[NW-1:0] = NW'(n);
        return w;
    endfunction

    function automatic string describe(input word_t a, input word_t b);
        for (int k = 0; k < MN; k++) begin
            if (a[SW-1-k*DW -: DW] !== b[SW-1-k*DW -: DW])
                return $sformatf("slot %0d got %h expected %h", k, a[SW-1-k*DW -: DW], b[SW-1-k*DW -: DW]);
        end
        return $sformatf("count got %0d expected %0d", a[NW-1:0], b[NW-1:0]);
    endfunction

    task automatic wait_words(input int target, input int budget, input string tag);
        int i = 0;
        while (cap_words.size() < target && i < budget) begin
            @(negedge clk);
            i++;
        end
        checks++;
        if (cap_words.size() < target) begin
            errors++;
            $display("FAIL %s_timeout: got %0d words, needed %0d", tag, cap_words.size(), target);
        end
        @(negedge clk);
    endtask

    task automatic push_coefs(input int n);
        for (int k = 0; k < n; k++) coef_q.push_back(exp_coefs[k]);
        fifo_refresh();
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        sm_rdy_i = 1'b0;
        fifo_refresh();
        repeat (2) @(negedge clk);
        checks++;
        if (sm_vld_o !== 1'b0 || sm_data_o !== '0) begin
            errors++;
            $display("FAIL reset_out: vld=%b data_low=%h, expected 0/0", sm_vld_o, sm_data_o[63:0]);
        end
        checks++;
        if (sg_done_cnt_o !== '0 || ovf_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_cnt: done=%0d ovf=%b, expected 0/0", sg_done_cnt_o, ovf_o);
        end
        checks++;
        if (coef_ff_rd_vld !== 1'b0 || num_node_ff_rd_vld !== 1'b0) begin
            errors++;
            $display("FAIL reset_rd: coef_rd=%b num_rd=%b, expected 0/0", coef_ff_rd_vld, num_node_ff_rd_vld);
        end
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (sm_vld_o !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_vld: got %b expected 0", sm_vld_o);
        end
    endtask

    task automatic test_basic();
        int base = cap_words.size();
        word_t exp_w;
        tick();
        sm_rdy_i = 1'b1;
        exp_coefs[0] = 8'h11; exp_coefs[1] = 8'h22; exp_coefs[2] = 8'h33;
        exp_w = mk_word(3);
        push_coefs(3);
        num_q.push_back(8'd3);
        fifo_refresh();
        wait_words(base + 1, 40, "basic");
        exp_done++;
        if (cap_words.size() > base) begin
            checks++;
            if (cap_words[base] !== exp_w) begin
                errors++;
                $display("FAIL basic_word: %s", describe(cap_words[base], exp_w));
            end
            checks++;
            if (cap_words[base][SW-1 -: 24] !== 24'h112233) begin
                errors++;
                $display("FAIL basic_top24: got %h expected 112233", cap_words[base][SW-1 -: 24]);
            end
        end
        checks++;
        if (sg_done_cnt_o !== SGW'(exp_done)) begin
            errors++;
            $display("FAIL basic_done: got %0d expected %0d", sg_done_cnt_o, exp_done);
        end
    endtask

    task automatic test_backpressure();
        int base = cap_words.size();
        int p_coef, p_num, i;
        word_t held, exp_w;
        tick();
        sm_rdy_i = 1'b0;
        exp_coefs[0] = 8'hAA; exp_coefs[1] = 8'hBB;
        exp_w = mk_word(2);
        push_coefs(2);
        num_q.push_back(8'd2);
        fifo_refresh();
        i = 0;
        while (!sm_vld_o && i < 40) begin
            @(negedge clk);
            i++;
        end
        checks++;
        if (sm_vld_o !== 1'b1) begin
            errors++;
            $display("FAIL bp_vld_timeout: vld=%b expected 1", sm_vld_o);
        end
        held   = sm_data_o;
        p_coef = coef_pops;
        p_num  = num_pops;
        tick();
        coef_q.push_back(8'h77);
        fifo_refresh();
        for (int c = 2; c <= 5; c++) begin
            if (c > 2) @(negedge clk);
            else @(negedge clk);
            checks++;
            if (sm_vld_o !== 1'b1 || sm_data_o !== held) begin
                errors++;
                $display("FAIL bp_hold_c%0d: vld=%b (expected 1), %s", c, sm_vld_o, describe(sm_data_o, held));
            end
        end
        tick();
        sm_rdy_i = 1'b1;
        @(negedge clk);
        checks++;
        if (sm_vld_o !== 1'b1 || sm_data_o !== held) begin
            errors++;
            $display("FAIL bp_hold_c6: vld=%b (expected 1), %s", sm_vld_o, describe(sm_data_o, held));
        end
        @(negedge clk);
        exp_done++;
        checks++;
        if (sm_vld_o !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: vld=%b expected 0", sm_vld_o);
        end
        checks++;
        if (coef_pops !== p_coef || num_pops !== p_num) begin
            errors++;
            $display("FAIL bp_pops: coef pops %0d expected %0d, num pops %0d expected %0d",
                     coef_pops, p_coef, num_pops, p_num);
        end
        checks++;
        if (cap_words.size() !== base + 1) begin
            errors++;
            $display("FAIL bp_accepts: got %0d accepts expected 1", cap_words.size() - base);
        end else begin
            checks++;
            if (cap_words[base] !== exp_w) begin
                errors++;
                $display("FAIL bp_word: %s", describe(cap_words[base], exp_w));
            end
        end
        checks++;
        if (sg_done_cnt_o !== SGW'(exp_done)) begin
            errors++;
            $display("FAIL bp_done: got %0d expected %0d", sg_done_cnt_o, exp_done);
        end
        tick();
        coef_q.delete();
        fifo_refresh();
    endtask

    task automatic test_starved();
        int base = cap_words.size();
        int v0 = viol;
        word_t exp_w;
        tick();
        sm_rdy_i  = 1'b1;
        starve_en = 1'b1;
        for (int k = 0; k < 4; k++) exp_coefs[k] = 8'(k + 1);
        exp_w = mk_word(4);
        push_coefs(4);
        num_q.push_back(8'd4);
        fifo_refresh();
        wait_words(base + 1, 60, "starved");
        exp_done++;
        tick();
        starve_en  = 1'b0;
        coef_block = 1'b0;
        fifo_refresh();
        checks++;
        if (viol !== v0) begin
            errors++;
            $display("FAIL starved_rd_while_empty: got %0d events expected 0", viol - v0);
        end
        if (cap_words.size() > base) begin
            checks++;
            if (cap_words[base] !== exp_w) begin
                errors++;
                $display("FAIL starved_word: %s", describe(cap_words[base], exp_w));
            end
        end
        checks++;
        if (vld_rise_cyc !== last_coef_pop_cyc + 1) begin
            errors++;
            $display("FAIL starved_latency: vld rose at %0d expected %0d", vld_rise_cyc, last_coef_pop_cyc + 1);
        end
    endtask

    task automatic test_n0();
        int base = cap_words.size();
        tick();
        num_q.push_back(8'd0);
        fifo_refresh();
        wait_words(base + 1, 20, "n0");
        exp_done++;
        if (cap_words.size() > base) begin
            checks++;
            if (cap_words[base] !== '0) begin
                errors++;
                $display("FAIL n0_word: %s", describe(cap_words[base], '0));
            end
        end
        checks++;
        if (sg_done_cnt_o !== SGW'(exp_done)) begin
            errors++;
            $display("FAIL n0_done: got %0d expected %0d", sg_done_cnt_o, exp_done);
        end
    endtask

    task automatic test_full(input int num_in, input string tag);
        int base = cap_words.size();
        word_t exp_w;
        tick();
        for (int k = 0; k < MN; k++) exp_coefs[k] = (num_in > MN) ? 8'(k * 3 + 7) : 8'(k + 1);
        exp_w = mk_word(MN);
        push_coefs(MN);
        num_q.push_back(NW'(num_in));
        fifo_refresh();
        wait_words(base + 1, 400, tag);
        exp_done++;
        if (cap_words.size() > base) begin
            checks++;
            if (cap_words[base] !== exp_w) begin
                errors++;
                $display("FAIL %s_word: %s", tag, describe(cap_words[base], exp_w));
            end
            checks++;
            if (cap_words[base][NW+7:NW] !== exp_coefs[MN-1]) begin
                errors++;
                $display("FAIL %s_last_slot: got %h expected %h", tag, cap_words[base][NW+7:NW], exp_coefs[MN-1]);
            end
        end
        checks++;
        if (ovf_o !== (num_in > MN)) begin
            errors++;
            $display("FAIL %s_ovf: got %b expected %b", tag, ovf_o, (num_in > MN));
        end
    endtask

    task automatic test_back_to_back();
        int base = cap_words.size();
        word_t wa, wb, wc;
        tick();
        exp_coefs[0] = 8'hC1; wa = mk_word(1);
        exp_coefs[0] = 8'hD1; exp_coefs[1] = 8'hD2; wb = mk_word(2);
        exp_coefs[0] = 8'hE1; wc = mk_word(1);
        coef_q.push_back(8'hC1);
        coef_q.push_back(8'hD1);
        coef_q.push_back(8'hD2);
        coef_q.push_back(8'hE1);
        num_q.push_back(8'd1);
        num_q.push_back(8'd2);
        num_q.push_back(8'd1);
        fifo_refresh();
        wait_words(base + 3, 60, "b2b");
        exp_done += 3;
        if (cap_words.size() >= base + 3) begin
            checks++;
            if (cap_words[base] !== wa) begin
                errors++;
                $display("FAIL b2b_word0: %s", describe(cap_words[base], wa));
            end
            checks++;
            if (cap_words[base+1] !== wb) begin
                errors++;
                $display("FAIL b2b_word1: %s", describe(cap_words[base+1], wb));
            end
            checks++;
            if (cap_words[base+2] !== wc) begin
                errors++;
                $display("FAIL b2b_word2: %s", describe(cap_words[base+2], wc));
            end
            checks++;
            if (cap_cyc[base+1] - cap_cyc[base] !== 4 || cap_cyc[base+2] - cap_cyc[base+1] !== 3) begin
                errors++;
                $display("FAIL b2b_spacing: got %0d,%0d cycles expected 4,3",
                         cap_cyc[base+1] - cap_cyc[base], cap_cyc[base+2] - cap_cyc[base+1]);
            end
        end
        checks++;
        if (sg_done_cnt_o !== SGW'(exp_done)) begin
            errors++;
            $display("FAIL b2b_done: got %0d expected %0d", sg_done_cnt_o, exp_done);
        end
        checks++;
        if (ovf_o !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: got %b expected 1", ovf_o);
        end
    endtask

    task automatic test_reset_mid();
        int base_pop = coef_pops;
        int base, p_coef, i;
        word_t exp_w;
        tick();
        sm_rdy_i = 1'b1;
        coef_q.push_back(8'h01);
        coef_q.push_back(8'h02);
        num_q.push_back(8'd5);
        fifo_refresh();
        i = 0;
        while (coef_pops < base_pop + 2 && i < 40) begin
            @(negedge clk);
            i++;
        end
        checks++;
        if (coef_pops !== base_pop + 2) begin
            errors++;
            $display("FAIL rmid_pops_timeout: got %0d pops expected 2", coef_pops - base_pop);
        end
        tick();
        rst_n = 1'b0;
        coef_q.delete();
        num_q.delete();
        fifo_refresh();
        @(negedge clk);
        exp_done = 0;
        checks++;
        if (sm_vld_o !== 1'b0 || sm_data_o !== '0 || sg_done_cnt_o !== '0 || ovf_o !== 1'b0) begin
            errors++;
            $display("FAIL rmid_clear: vld=%b data_zero=%b done=%0d ovf=%b, expected 0/1/0/0",
                     sm_vld_o, (sm_data_o == '0), sg_done_cnt_o, ovf_o);
        end
        tick();
        rst_n = 1'b1;
        coef_q.push_back(8'h5A);
        coef_q.push_back(8'h5B);
        coef_q.push_back(8'h5C);
        fifo_refresh();
        base   = cap_words.size();
        p_coef = coef_pops;
        repeat (10) @(negedge clk);
        checks++;
        if (coef_pops !== p_coef || sm_vld_o !== 1'b0 || cap_words.size() !== base) begin
            errors++;
            $display("FAIL rmid_idle: pops=%0d vld=%b words=%0d, expected 0/0/0",
                     coef_pops - p_coef, sm_vld_o, cap_words.size() - base);
        end
        tick();
        exp_coefs[0] = 8'h5A;
        exp_w = mk_word(1);
        num_q.push_back(8'd1);
        fifo_refresh();
        wait_words(base + 1, 20, "rmid");
        exp_done++;
        if (cap_words.size() > base) begin
            checks++;
            if (cap_words[base] !== exp_w) begin
                errors++;
                $display("FAIL rmid_word: %s", describe(cap_words[base], exp_w));
            end
        end
        checks++;
        if (sg_done_cnt_o !== SGW'(exp_done)) begin
            errors++;
            $display("FAIL rmid_done: got %0d expected %0d", sg_done_cnt_o, exp_done);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_starved();
        test_n0();
        test_full(168, "n168");
        test_full(200, "n200");
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (viol !== 0) begin
            errors++;
            $display("FAIL rd_while_empty_total: got %0d expected 0", viol);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/coef_collector.md
Name: coef_collector

Overview:
- Downstream neighbour of the attention-coefficient (DMVM) stage.
- Drains the 8-bit ReLU'd coefficient FIFO that DMVM writes, one coefficient per neighbour node.
- Packs each subgraph's coefficients into one SOFTMAX_WIDTH word (coefficients + node count) and hands it to the softmax stage with a valid/ready handshake.
- Node count per subgraph comes from a separate num_node FIFO, written by the WH stage.

Parameters:
- DATA_WIDTH, 8, coefficient width.
- MAX_NODES, 168, maximum nodes per subgraph (slots in output vector).
- NUM_SUBGRAPHS, 2708, subgraphs per inference; sizes the done counter.
- NUM_NODE_WIDTH (local), $clog2(MAX_NODES), node-count field width.
- SOFTMAX_WIDTH (local), MAX_NODES*DATA_WIDTH+NUM_NODE_WIDTH, output word width.
- SG_CNT_W (local), $clog2(NUM_SUBGRAPHS+1), subgraph counter width.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, asynchronous active-low reset.
- coef_ff_dout, input, DATA_WIDTH, head of coefficient FIFO (first-word-fall-through).
- coef_ff_empty, input, 1, coefficient FIFO empty.
- coef_ff_rd_vld, output, 1, pop coefficient FIFO this cycle.
- num_node_ff_dout, input, NUM_NODE_WIDTH, head of node-count FIFO (FWFT).
- num_node_ff_empty, input, 1, node-count FIFO empty.
- num_node_ff_rd_vld, output, 1, pop node-count FIFO this cycle.
- sm_data_o, output, SOFTMAX_WIDTH, packed coefficient vector + node count.
- sm_vld_o, output, 1, sm_data_o valid.
- sm_rdy_i, input, 1, softmax accepts word.
- sg_done_cnt_o, output, SG_CNT_W, number of words accepted by softmax.
- ovf_o, output, 1, sticky: a node count above MAX_NODES was seen.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, port rst_n.
- Reset values: all outputs 0; FSM IDLE; buffer and counters cleared; ovf_o 0.
- FIFO pop rule: a FIFO is popped only when its rd_vld and !empty are both high in the same cycle. rd_vld is never asserted while empty.
- IDLE:
  - If !num_node_ff_empty: pop it and latch n = min(num_node_ff_dout, MAX_NODES).
  - If num_node_ff_dout > MAX_NODES, set ovf_o.
  - Zero the buffer and reset slot counter cnt to 0.
  - Go to COLLECT if n>0; otherwise go to OUTPUT.
- COLLECT:
  - coef_ff_rd_vld = !coef_ff_empty. On each pop, write coef_ff_dout to slot cnt and increment cnt.
  - Stall (hold state, no writes) while the FIFO is empty.
  - On the pop where cnt==n-1, go to OUTPUT.
- OUTPUT:
  - sm_vld_o=1. sm_data_o is held stable until sm_rdy_i.
  - On sm_vld_o&&sm_rdy_i: increment sg_done_cnt_o and go to IDLE.
  - If sm_rdy_i is already high on the first OUTPUT cycle, transfer completes in that cycle.
- Packing:
  - Slot k occupies sm_data_o[SOFTMAX_WIDTH-1-k*DATA_WIDTH -: DATA_WIDTH]; slot 0 is at the MSB.
  - sm_data_o[NUM_NODE_WIDTH-1:0] = n after clamping.
  - Slots >= n are 0.
- Latency:
  - sm_vld_o rises the cycle after the last coefficient pop.
  - One idle cycle between the accepted output and the next num_node pop.
  - Best-case throughput: n+2 cycles per subgraph.
- Coefficients are unsigned pass-through (already ReLU'd upstream); no arithmetic on data.
- Counter wrap: sg_done_cnt_o wraps to 0 after NUM_SUBGRAPHS accepts.
- Extra input: coefficients arriving while in IDLE or OUTPUT are not popped; they stay in the FIFO.
- Reset mid-operation: reset asserted during COLLECT or OUTPUT clears all state immediately. The partial vector is discarded; there is no FIFO flush (FIFOs have their own reset).

Decomposition:
- gat_pkg holds: the FSM state enum {IDLE, COLLECT, OUTPUT}, the NUM_NODE_WIDTH/SOFTMAX_WIDTH derivations, and a function that computes a slot's bit offset.
- One sub-module, coef_pack_buf: a MAX_NODES x DATA_WIDTH register buffer with clear, write-enable and write index, exposing the flattened vector.
- FSM, counters and handshake stay in the top module.

Test Plan:
- Basic pack: num_node=3, coefs 0x11,0x22,0x33, sm_rdy_i=1 → one word; top 24 bits 0x112233, remaining slots 0, low field 3; sg_done_cnt_o=1.
- Backpressure: n=2, sm_rdy_i low for 5 cycles → sm_vld_o held and sm_data_o stable for 6 cycles; no pops of either FIFO meanwhile; single accept.
- Starved FIFO: n=4 with coef_ff_empty toggling every other cycle → coef_ff_rd_vld never high while empty; word correct; sm_vld_o one cycle after 4th pop.
- Boundaries:
  - n=0 → zero-coefficient word (count 0) emitted.
  - n=168 → all slots filled, last coefficient in bits [NUM_NODE_WIDTH+7:NUM_NODE_WIDTH].
  - n=200 → clamped to 168, ovf_o=1 and stays high.
- Back-to-back: 3 subgraphs (n=1,2,1) preloaded, sm_rdy_i=1 → 3 words with previous slots cleared (no stale data); sg_done_cnt_o=3.
- Reset mid-COLLECT: assert rst_n=0 after 2 of 5 pops → all outputs 0 next sample; after release, IDLE and no output until new num_node.
